// File: rtl/imem_responder_if.sv
// Fetch/response and image-load bundle between the IF stage (master) and
// the instruction-memory responder (slave).
interface imem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic              flush;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] inst_data;
    logic              inst_valid;
    logic              busy;
    logic              addr_err;

    modport master (
        output mem_read, mem_addr, flush, load_we, load_addr, load_data,
        input  inst_data, inst_valid, busy, addr_err
    );

    modport slave (
        input  mem_read, mem_addr, flush, load_we, load_addr, load_data,
        output inst_data, inst_valid, busy, addr_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency fetch with flush cancel,
// sticky out-of-range flag and a write-only image-load port.
module imem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    imem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [DATA_W-1:0] held_r, held_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              accept_s;
    logic              fetch_ok_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              valid_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;
    logic              err_s;

    logic              inst_valid_r;
    logic [DATA_W-1:0] inst_data_r;
    logic              busy_r;
    logic              addr_err_r;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction

    // Next-state, counter, holding word and next output values
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        held_s     = held_r;
        fetch_ok_s = in_range(bus.mem_addr);
        rd_word_s  = fetch_ok_s ? mem_r[bus.mem_addr[IDX_W-1:0]] : {DATA_W{1'b0}};
        // A flush frees the responder, so the branch target is taken even mid-wait
        accept_s   = bus.mem_read && ((state_r != WAIT) || bus.flush);

        if (accept_s) begin
            held_s  = rd_word_s;
            cnt_s   = CNT_W'(LATENCY - 1);
            state_s = (LATENCY == 1) ? DONE : WAIT;
        end else if (bus.flush) begin
            cnt_s   = {CNT_W{1'b0}};
            state_s = IDLE;
        end else begin
            case (state_r)
                WAIT: begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    state_s = (cnt_r == CNT_W'(1)) ? DONE : WAIT;
                end
                DONE:    state_s = IDLE;
                IDLE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end

        valid_s = (state_s == DONE);
        data_s  = valid_s ? held_s : {DATA_W{1'b0}};
        busy_s  = (state_s == WAIT);
        err_s   = addr_err_r | (accept_s & ~fetch_ok_s);
    end

    // State, counter, holding word and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            held_r       <= {DATA_W{1'b0}};
            inst_valid_r <= 1'b0;
            inst_data_r  <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            addr_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            held_r       <= held_s;
            inst_valid_r <= valid_s;
            inst_data_r  <= data_s;
            busy_r       <= busy_s;
            addr_err_r   <= err_s;
        end
    end

    // Image-load write port; the array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (bus.load_we && in_range(bus.load_addr)) begin
            mem_r[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
        end
    end

    assign bus.inst_valid = inst_valid_r;
    assign bus.inst_data  = inst_data_r;
    assign bus.busy       = busy_r;
    assign bus.addr_err   = addr_err_r;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder serving the IF stage's fetch requests. It samples `mem_read`/`mem_addr` and returns the addressed 32-bit instruction after a fixed, parameterised latency, with a one-cycle `inst_valid` strobe. It supports cancelling an in-flight fetch on a taken branch. It also provides a write-only load port for boot and testbench image loading, and sits between the IF stage and the instruction storage array.

## Interface
Parameters:
- `DATA_W`, 32, instruction width.
- `ADDR_W`, 32, request address width; the address is a word index, not a byte address.
- `DEPTH`, 1024, number of instruction words; a power of two.
- `LATENCY`, 1, request-to-data cycles; legal range 1..4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: synchronous, active-high.
- `mem_read`  in  1  fetch request, sampled every cycle.
- `mem_addr`  in  ADDR_W  fetch word address, sampled with `mem_read`.
- `flush`  in  1  cancel any in-flight fetch (taken branch).
- `load_we`  in  1  image-load write enable.
- `load_addr`  in  ADDR_W  image-load word address.
- `load_data`  in  DATA_W  image-load word.
- `inst_data`  out  DATA_W  returned instruction; 0 whenever `inst_valid`=0.
- `inst_valid`  out  1  `inst_data` valid this cycle (one-cycle strobe per request).
- `busy`  out  1  request in flight; a new `mem_read` is not accepted.
- `addr_err`  out  1  sticky flag: an accepted request had `mem_addr` >= DEPTH.

## Operation
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- **Accept rule.** A request is accepted when `mem_read`=1 and the state is IDLE or DONE.
  - The array word is read into the holding register at acceptance.
  - Out-of-range addresses return 0 and set `addr_err`.
  - The counter loads LATENCY-1.
- **After acceptance.**
  - If LATENCY=1, next state is DONE.
  - Otherwise next state is WAIT; the counter decrements each cycle and the FSM moves to DONE when the counter reaches 0.
- **DONE.**
  - `inst_valid`=1 and `inst_data` = held word, for exactly one cycle.
  - Next state is WAIT/DONE if a new request is accepted that cycle, else IDLE.
- **busy.** `busy`=1 exactly when the state is WAIT. `mem_read` during WAIT is ignored; the requester holds it.
- **flush.**
  - In any state, the pending request is discarded: no `inst_valid` is produced for it.
  - If `mem_read`=1 in the same cycle, that new request is accepted as a fresh request (branch target wins).
  - If flush and `inst_valid`=1 coincide, the strobe already on the outputs stands; the requester discards it.
- **Load port.**
  - `load_we` writes `load_data` to `load_addr[log2(DEPTH)-1:0]` at the clock edge. Writes with `load_addr` >= DEPTH are dropped.
  - A load and an accepted fetch to the same address in the same cycle: the fetch returns the old word.
- **Reset.**
  - Clears state to IDLE, counter to 0, `inst_valid` to 0, `inst_data` to 0, `busy` to 0, `addr_err` to 0.
  - Array contents are not cleared.
  - `rst` mid-request drops the request.

## Timing
- Request accepted at edge N → `inst_valid`=1 in cycle N+LATENCY.
- Throughput:
  - LATENCY=1: one fetch per cycle with back-to-back `mem_read`.
  - LATENCY=L: one fetch per L cycles.
- `busy` rises the cycle after acceptance when LATENCY>1. It falls in the cycle `inst_valid` rises.
- A flush at edge F suppresses every strobe that would occur after F. The first valid strobe after flush is for the request accepted at F or later.
- `addr_err` rises one cycle after the offending acceptance and stays set until `rst`.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `mem_read`=1 → `inst_valid`=0, `busy`=0, `inst_data`=0, `addr_err`=0 throughout.
- **Load, then single-cycle fetch.**
  - Load word 5 = 0x00A00093; LATENCY=1; `mem_read`=1, `mem_addr`=5 at edge N.
  - → `inst_data`=0x00A00093 and `inst_valid`=1 in cycle N+1 only.
- **Back-to-back at LATENCY=1.**
  - Addresses 0,1,2 on consecutive cycles.
  - → three consecutive valid strobes with the matching words, `busy` never asserted.
- **LATENCY=3.**
  - Fetch addr 7 at edge N with `mem_read` held.
  - → `busy`=1 in cycles N+1..N+2, `inst_valid`=1 in cycle N+3, next acceptance at edge N+3.
- **Flush mid-flight (LATENCY=3).**
  - Fetch addr 4 at N; flush plus `mem_read` for addr 20 at N+1.
  - → no strobe for addr 4; word 20 valid in cycle N+4.
- **Out of range.**
  - Fetch addr DEPTH+3.
  - → `inst_data`=0 with `inst_valid`=1; `addr_err`=1 from the next cycle, still set 10 cycles later; cleared only by `rst`.
